// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and key-code helpers for the 4x4 matrix keypad
//               scanner and the keypad emulator.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_BNC = 3'd1,
        HOLD      = 3'd2,
        REL_BNC   = 3'd3,
        GAP       = 3'd4
    } kp_state_e;

    // Row index of a key: upper two bits of the key code.
    function automatic logic [1:0] key_row_idx(input logic [KEY_W-1:0] key);
        return key[3:2];
    endfunction

    // Column index of a key: lower two bits of the key code.
    function automatic logic [1:0] key_col_idx(input logic [KEY_W-1:0] key);
        return key[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_row_drive.sv
`default_nettype none
// ============================================================================
// Module      : keypad_row_drive
// Description : Combinational row sense for one closed key contact. The row
//               line of the key is pulled low only while the key's column is
//               driven to a definite low by the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_row_drive
    import keypad_pkg::*;
(
    input  logic             contact,
    input  logic [KEY_W-1:0] key,
    input  logic [3:0]       col,
    output logic [3:0]       row
);

    logic [1:0] w_row_idx;
    logic [1:0] w_col_idx;

    assign w_row_idx = key_row_idx(key);
    assign w_col_idx = key_col_idx(key);

    // Pull the key's row low while contact is closed and its column is low;
    // an unknown column level falls through to the released value.
    always_comb begin
        row = 4'b1111;
        if (contact && !col[w_col_idx]) begin
            row[w_row_idx] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : keypad_emulator
// Description : Key-side responder for a 4x4 matrix keypad scanner. Plays one
//               "press key N for H cycles" command at a time, with contact
//               bounce on press and release and a released gap afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 1000,
    parameter int BOUNCE_STEP   = 64,
    parameter int GAP_CYCLES    = 1000,
    parameter int HOLD_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        col,
    output logic [3:0]        row,
    output logic              busy,
    output logic              done
);

    localparam int c_max_par   = (BOUNCE_CYCLES > GAP_CYCLES)
                               ? ((BOUNCE_CYCLES > BOUNCE_STEP) ? BOUNCE_CYCLES : BOUNCE_STEP)
                               : ((GAP_CYCLES > BOUNCE_STEP) ? GAP_CYCLES : BOUNCE_STEP);
    localparam int c_par_bits  = $clog2(c_max_par + 1);
    localparam int c_cnt_w     = (HOLD_W > c_par_bits) ? HOLD_W : c_par_bits;
    localparam int c_step_w    = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;
    localparam int c_bnc_last  = (BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0;
    localparam int c_gap_last  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int c_step_last = (BOUNCE_STEP > 1) ? BOUNCE_STEP - 1 : 0;

    kp_state_e           r_state;
    kp_state_e           w_state_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_step_w-1:0] r_step;
    logic [KEY_W-1:0]    r_key_q;
    logic [HOLD_W-1:0]   r_hold_q;
    logic                r_contact;
    logic                r_done;
    logic                w_accept;
    logic                w_last;
    logic                w_step_wrap;
    logic [c_cnt_w-1:0]  w_hold_last;

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_step_wrap = (r_step == c_step_w'(c_step_last));
    // hold_q is never zero, so hold_q-1 cannot underflow.
    assign w_hold_last = c_cnt_w'(r_hold_q) - c_cnt_w'(1);

    // State register; async reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: each timed state ends when cnt reaches its last cycle.
    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (BOUNCE_CYCLES == 0) ? HOLD : PRESS_BNC;
                end
            end
            PRESS_BNC: begin
                w_last = (r_cnt == c_cnt_w'(c_bnc_last));
                if (w_last) w_state_next = HOLD;
            end
            HOLD: begin
                w_last = (r_cnt == w_hold_last);
                if (w_last) w_state_next = (BOUNCE_CYCLES == 0) ? GAP : REL_BNC;
            end
            REL_BNC: begin
                w_last = (r_cnt == c_cnt_w'(c_bnc_last));
                if (w_last) w_state_next = GAP;
            end
            GAP: begin
                w_last = (r_cnt == c_cnt_w'(c_gap_last));
                if (w_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        done      = r_done;
    end

    // Datapath: counters cleared on every state entry, command latch,
    // registered contact level and the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_step    <= '0;
            r_key_q   <= '0;
            r_hold_q  <= '0;
            r_contact <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == GAP) && (w_state_next == IDLE);

            if (w_state_next != r_state) begin
                r_cnt  <= '0;
                r_step <= '0;
            end else if (r_state != IDLE) begin
                r_cnt  <= r_cnt + c_cnt_w'(1);
                r_step <= w_step_wrap ? '0 : r_step + c_step_w'(1);
            end

            if (w_accept) begin
                r_key_q  <= cmd_key;
                r_hold_q <= (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
            end

            case (w_state_next)
                PRESS_BNC: r_contact <= (r_state != PRESS_BNC) ? 1'b1
                                      : (w_step_wrap ? ~r_contact : r_contact);
                HOLD:      r_contact <= 1'b1;
                REL_BNC:   r_contact <= (r_state != REL_BNC) ? 1'b0
                                      : (w_step_wrap ? ~r_contact : r_contact);
                default:   r_contact <= 1'b0;
            endcase
        end
    end

    keypad_row_drive u_row_drive (
        .contact (r_contact),
        .key     (r_key_q),
        .col     (col),
        .row     (row)
    );

endmodule
`default_nettype wire
